// File: rtl/ahb_slave_pkg.sv
// Shared definitions for the AHB-Lite SRAM slave: bus encodings, FSM states
// and the byte-lane decode used on writes.
package ahb_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int MAX_LANES = 8;
  localparam int CNT_BITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane mask: lane i carries byte address (word base + i).
  function automatic logic [MAX_LANES-1:0] byte_lanes(
    input logic [2:0] size,
    input logic [2:0] addr_lo,
    input int         data_width
  );
    int lanes;
    int off;
    int span;
    logic [MAX_LANES-1:0] en;
    lanes = data_width / 8;
    off   = int'(addr_lo) & (lanes - 1);
    span  = 1 << size;
    en    = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      en[i] = (i >= off) && (i < off + span) && (i < lanes);
    end
    return en;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and an
// asynchronous read port sharing the same word address.
module ahb_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic [DATA_WIDTH/8-1:0]    byte_en,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; resetting storage would turn it
  // into a huge flop bank with a reset net, and software never relies on it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (byte_en[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite leaf slave in front of a byte-addressable SRAM, with programmable
// wait states, byte-lane writes and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int OFF_BITS  = LANE_BITS + IDX_BITS;
  localparam logic [63:0]         MEM_BYTES = 64'(DEPTH) * 64'(LANES);
  localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                valid_q;
  logic                err_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic [OFF_BITS-1:0] addr_q;

  logic                ready_out;
  logic                resp_err;
  logic                take;
  logic                size_bad, align_bad, range_bad, err_in;
  logic                wr_commit;
  logic                rd_phase;
  logic [LANES-1:0]    byte_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                unused_burst;

  // Bursts need no special handling: every beat carries its own address.
  assign unused_burst = ^HBURST;

  // A data phase ends on any edge where this slave drives HREADYOUT high.
  assign ready_out = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                     ((state_q == ST_WAIT) && (cnt_q == '0));
  assign resp_err  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

  assign take = HSEL && HREADY && ready_out &&
                ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    size_bad  = int'(HSIZE) > LANE_BITS;
    align_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((i < int'(HSIZE)) && HADDR[i]) align_bad = 1'b1;
    end
    range_bad = 64'(HADDR) >= MEM_BYTES;
    err_in    = size_bad || align_bad || range_bad;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase
    if (ready_out) begin
      state_d = ST_IDLE;
      if (take) begin
        if (err_in) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address-phase registers advance only when the current data phase ends.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
    end else if (ready_out) begin
      valid_q <= take;
      if (take) begin
        err_q   <= err_in;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        addr_q  <= HADDR[OFF_BITS-1:0];
      end
    end
  end

  // Reset on the completing edge wins over the write.
  assign wr_commit = valid_q && !err_q && write_q && ready_out && !HRESET;
  assign rd_phase  = valid_q && !err_q && !write_q;

  assign byte_en = wr_commit ?
                   LANES'(byte_lanes(size_q, 3'(addr_q[LANE_BITS-1:0]), DATA_WIDTH)) :
                   '0;

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (HCLK),
    .byte_en (byte_en),
    .addr    (addr_q[OFF_BITS-1:LANE_BITS]),
    .wdata   (HWDATA),
    .rdata   (rd_word)
  );

  assign HREADYOUT = ready_out;
  assign HRESP     = resp_err ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = rd_phase ? rd_word : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) driven through a
// pipelined AHB master, directed tables, hand sequences and random traffic.
module tb_ahb_sram_slave;
  import ahb_slave_pkg::*;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int DEPTH     = 1024;
  localparam int MEM_BYTES = DEPTH * DW / 8;
  localparam int LIMIT     = 3000;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } tr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel0, sel3, block;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize, hburst;
  logic [DW-1:0] hwdata;
  logic          rdy0, rdy3, resp0, resp3;
  logic [DW-1:0] rdata0, rdata3;
  logic          ready, resp;
  logic [DW-1:0] rdata;

  int  w_act;
  int  checks = 0;
  int  errors = 0;
  tr_t txq[$];
  logic [7:0] mref [2][MEM_BYTES];

  always #5 clk = ~clk;

  ahb_sram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy0 & ~block), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  ahb_sram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy3 & ~block), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3));

  assign ready = (w_act == 3) ? rdy3   : rdy0;
  assign resp  = (w_act == 3) ? resp3  : resp0;
  assign rdata = (w_act == 3) ? rdata3 : rdata0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input bit valid, input tr_t t, input bit seq);
    sel0   = valid && (w_act == 0);
    sel3   = valid && (w_act == 3);
    htrans = valid ? (seq ? HTRANS_SEQ : HTRANS_NONSEQ) : HTRANS_IDLE;
    haddr  = t.addr;
    hwrite = t.wr;
    hsize  = t.size;
    hburst = 3'd1;
  endtask

  // Pipelined master: the next address phase is shown during the current
  // data phase and taken when the slave is ready.
  task automatic run_queue();
    int  nxt   = 0;
    int  dp    = -1;
    int  k     = 0;
    int  guard = 0;
    int  exp_last;
    bit  rdy_s;
    tr_t cur;
    tr_t none;
    none = '{default: '0};
    @(posedge clk); #1;
    present(txq.size() > 0, (txq.size() > 0) ? txq[0] : none, 1'b0);
    while ((nxt < txq.size() || dp >= 0) && guard < LIMIT) begin
      guard++;
      @(negedge clk);
      rdy_s = ready;
      if (dp >= 0) begin
        cur      = txq[dp];
        exp_last = cur.err ? 1 : w_act;
        check($sformatf("W%0d t%0d c%0d hreadyout", w_act, dp, k), ready, (k == exp_last));
        check($sformatf("W%0d t%0d c%0d hresp", w_act, dp, k), resp, cur.err);
        if (ready) check($sformatf("W%0d t%0d hrdata", w_act, dp), rdata, cur.rdata);
        k++;
        if (k > 20) begin
          check($sformatf("W%0d t%0d data phase length", w_act, dp), k, exp_last + 1);
          guard = LIMIT;
        end
      end else begin
        check($sformatf("W%0d idle hreadyout", w_act), ready, 1);
        check($sformatf("W%0d idle hresp", w_act), resp, 0);
        check($sformatf("W%0d idle hrdata", w_act), rdata, 0);
      end
      @(posedge clk);
      if (rdy_s) begin
        dp = (nxt < txq.size()) ? nxt : -1;
        if (nxt < txq.size()) nxt++;
        k = 0;
        #1;
        hwdata = (dp >= 0 && txq[dp].wr) ? txq[dp].wdata : $urandom;
        present(nxt < txq.size(), (nxt < txq.size()) ? txq[nxt] : none, 1'b1);
      end
    end
    check("run_queue timeout", guard >= LIMIT, 0);
    txq.delete();
  endtask

  // Reference model: byte-addressed memory, transfer rules applied directly.
  task automatic add(input int m, input bit wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata);
    tr_t t;
    int  mi;
    int  base;
    int  a;
    mi      = (m == 3) ? 1 : 0;
    t.wr    = wr;
    t.addr  = addr;
    t.size  = size;
    t.wdata = wdata;
    t.rdata = '0;
    t.err   = (size > 3'd2) || ((addr & ((32'd1 << size) - 32'd1)) != 0) ||
              (addr >= 32'(MEM_BYTES));
    if (!t.err) begin
      if (wr) begin
        for (int b = 0; b < (1 << size); b++) begin
          a = int'(addr) + b;
          mref[mi][a] = wdata[8*(a % 4) +: 8];
        end
      end else begin
        base    = int'(addr) & ~3;
        t.rdata = {mref[mi][base+3], mref[mi][base+2], mref[mi][base+1], mref[mi][base]};
      end
    end
    txq.push_back(t);
  endtask

  task automatic no_xfer(input string name, input logic [1:0] tr, input bit s, input bit blk);
    @(posedge clk); #1;
    w_act = 0; sel0 = s; sel3 = 1'b0; htrans = tr; hwrite = 1'b1;
    haddr = 32'h10; hsize = HSIZE_WORD; block = blk;
    @(posedge clk); #1;
    hwdata = 32'hBAD0_BAD0; sel0 = 1'b0; htrans = HTRANS_IDLE; block = 1'b0;
    @(negedge clk);
    check({name, " hreadyout"}, rdy0, 1);
    check({name, " hresp"}, resp0, 0);
    check({name, " hrdata"}, rdata0, 0);
  endtask

  tr_t vec0 [17];
  tr_t vec3 [7];

  initial begin
    tr_t rt;
    logic [31:0] ra;
    logic [2:0]  rs;

    vec0 = '{
      '{1'b1, 32'h10,   HSIZE_WORD,  32'hDEADBEEF, 1'b0, 32'h0},
      '{1'b0, 32'h10,   HSIZE_WORD,  32'h0,        1'b0, 32'hDEADBEEF},
      '{1'b1, 32'h10,   HSIZE_WORD,  32'h11223344, 1'b0, 32'h0},
      '{1'b1, 32'h13,   HSIZE_BYTE,  32'hAA000000, 1'b0, 32'h0},
      '{1'b0, 32'h10,   HSIZE_WORD,  32'h0,        1'b0, 32'hAA223344},
      '{1'b1, 32'h00,   HSIZE_WORD,  32'h01020304, 1'b0, 32'h0},
      '{1'b1, 32'h1000, HSIZE_WORD,  32'h12345678, 1'b1, 32'h0},
      '{1'b0, 32'h00,   HSIZE_WORD,  32'h0,        1'b0, 32'h01020304},
      '{1'b1, 32'h01,   HSIZE_HALF,  32'hFFFFFFFF, 1'b1, 32'h0},
      '{1'b0, 32'h10,   HSIZE_DWORD, 32'h0,        1'b1, 32'h0},
      '{1'b0, 32'h02,   HSIZE_BYTE,  32'h0,        1'b0, 32'h01020304},
      '{1'b1, 32'h12,   HSIZE_HALF,  32'h55660000, 1'b0, 32'h0},
      '{1'b0, 32'h10,   HSIZE_WORD,  32'h0,        1'b0, 32'h55663344},
      '{1'b1, 32'hFFC,  HSIZE_WORD,  32'hCAFEF00D, 1'b0, 32'h0},
      '{1'b1, 32'hFFF,  HSIZE_BYTE,  32'h77000000, 1'b0, 32'h0},
      '{1'b0, 32'hFFC,  HSIZE_WORD,  32'h0,        1'b0, 32'h77FEF00D},
      '{1'b0, 32'h01,   HSIZE_HALF,  32'h0,        1'b1, 32'h0}
    };
    vec3 = '{
      '{1'b1, 32'h20,   HSIZE_WORD, 32'hA1A2A3A4, 1'b0, 32'h0},
      '{1'b1, 32'h24,   HSIZE_WORD, 32'hB1B2B3B4, 1'b0, 32'h0},
      '{1'b1, 32'h26,   HSIZE_HALF, 32'hC5C60000, 1'b0, 32'h0},
      '{1'b0, 32'h20,   HSIZE_WORD, 32'h0,        1'b0, 32'hA1A2A3A4},
      '{1'b0, 32'h24,   HSIZE_WORD, 32'h0,        1'b0, 32'hC5C6B3B4},
      '{1'b1, 32'h1020, HSIZE_WORD, 32'h99999999, 1'b1, 32'h0},
      '{1'b0, 32'h20,   HSIZE_WORD, 32'h0,        1'b0, 32'hA1A2A3A4}
    };

    rt = '{default: '0};
    rst = 1'b1; block = 1'b0; w_act = 0; hwdata = '0;
    present(1'b0, rt, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset hreadyout W0", rdy0, 1);
    check("reset hresp W0", resp0, 0);
    check("reset hrdata W0", rdata0, 0);
    check("reset hreadyout W3", rdy3, 1);
    check("reset hresp W3", resp3, 0);
    check("reset hrdata W3", rdata3, 0);
    @(posedge clk); #1 rst = 1'b0;

    w_act = 0;
    foreach (vec0[i]) txq.push_back(vec0[i]);
    run_queue();

    no_xfer("idle", HTRANS_IDLE, 1'b1, 1'b0);
    no_xfer("busy", HTRANS_BUSY, 1'b1, 1'b0);
    no_xfer("hsel low", HTRANS_NONSEQ, 1'b0, 1'b0);
    no_xfer("hready low", HTRANS_NONSEQ, 1'b1, 1'b1);
    w_act = 0;
    txq.push_back('{1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'h55663344});
    run_queue();

    w_act = 3;
    foreach (vec3[i]) txq.push_back(vec3[i]);
    run_queue();

    // Reset lands in the second wait cycle of a pending write.
    @(posedge clk); #1;
    w_act = 3; sel3 = 1'b1; sel0 = 1'b0; htrans = HTRANS_NONSEQ;
    hwrite = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    present(1'b0, rt, 1'b0);
    hwdata = 32'h0BADF00D;
    @(negedge clk);
    check("rst-mid wait1 hreadyout", rdy3, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst-mid wait2 hreadyout", rdy3, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst-mid after hreadyout", rdy3, 1);
    check("rst-mid after hresp", resp3, 0);
    check("rst-mid after hrdata", rdata3, 0);
    txq.push_back('{1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'hA1A2A3A4});
    run_queue();

    // Random traffic on the low 64 bytes plus out-of-range and misaligned.
    foreach (vec3[i]) begin
      if (i < 2) begin
        w_act = (i == 0) ? 0 : 3;
        for (int wd = 0; wd < 16; wd++) add(w_act, 1'b1, 32'(wd * 4), HSIZE_WORD, $urandom);
        run_queue();
        for (int n = 0; n < 80; n++) begin
          rs = 3'($urandom_range(0, 3));
          ra = ($urandom_range(0, 7) == 0) ? 32'(MEM_BYTES + $urandom_range(0, 63))
                                           : 32'($urandom_range(0, 63));
          if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
          add(w_act, 1'($urandom_range(0, 1)), ra, rs, $urandom);
        end
        run_queue();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave with a byte-addressable on-chip SRAM behind it. It generalises the current fixed-width slave under verification with configurable data width, depth and wait states, and adds sub-word transfers with byte lanes plus a two-cycle ERROR response. It sits on the AHB bus as a leaf slave, selected by the decoder through HSEL, and is the DUT for the next generation of the AHB bench.

## Interface
- DATA_WIDTH, 32, bus data width in bits; one of 32 or 64.
- ADDR_WIDTH, 32, HADDR width.
- DEPTH, 1024, number of DATA_WIDTH-bit words; power of two.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- HBURST  in  3  burst type; accepted and ignored, because addresses come from the master.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is taken only when this is high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.

## Operation
- **Address phase accept.** An address phase is accepted on a rising edge when HSEL & HREADY & HTRANS[1]. On accept, register the address, write flag, size and an error flag.
- **No-transfer cases.** IDLE, BUSY, or HSEL low produce a zero-wait OKAY and never touch memory.
- **Error conditions.** The transfer errors if any of these hold:
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is not aligned to 2^HSIZE;
  - HADDR ≥ DEPTH·DATA_WIDTH/8.
- **State machine** (states IDLE, WAIT, ERR1, ERR2):
  - IDLE → WAIT on accepting a good transfer when WAIT_STATES > 0.
  - IDLE → ERR1 on accepting an errored transfer.
  - For a good transfer with WAIT_STATES = 0, stay in IDLE and complete in one cycle.
  - WAIT counts down WAIT_STATES cycles with HREADYOUT = 0, then completes (HREADYOUT = 1) and returns to IDLE. The next address may be accepted in that same cycle.
  - ERR1: HREADYOUT = 0, HRESP = 1. Always → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. → IDLE. A new address phase accepted in ERR2 is processed normally.
- **Write.** The write commits on the completing data-phase edge. HWDATA is gated by byte lanes derived from HSIZE and the low address bits, using little-endian lane mapping. Unselected bytes are unchanged.
- **Read.** HRDATA = full word mem[addr_q] during a read data phase; the master extracts the lanes. At all other times HRDATA = 0.
- **Errored transfers** never write memory and return HRDATA = 0.
- **Reset.** HREADYOUT = 1, HRESP = 0, HRDATA = 0, state IDLE, wait counter 0. Memory contents are not reset.
- **Reset mid-transfer.** A reset during a pending write aborts it with no memory update.

## Timing
- With WAIT_STATES = W, an OKAY data phase occupies W+1 cycles; HRDATA is valid in the final cycle.
- An ERROR data phase always occupies exactly 2 cycles, regardless of W.
- A write's memory update is visible to a read whose address phase coincides with the write's final data cycle. No forwarding is needed because the read data phase starts after the write edge.
- With W = 0, back-to-back NONSEQ/SEQ transfers sustain one transfer per cycle.
- A transfer accepted while the previous one is completing is pipelined with no bubble.

## Structure
- Shared package ahb_slave_pkg holds:
  - HTRANS, HSIZE and HRESP encodings as constants;
  - the state enum (IDLE, WAIT, ERR1, ERR2);
  - a function returning byte-lane enables from (size, addr low bits, DATA_WIDTH).
- Sub-module ahb_sram_array: DEPTH × DATA_WIDTH register array with a per-byte write enable and asynchronous read. Parametrised on DATA_WIDTH and DEPTH.
- The top level holds the address-phase registers, the FSM, the wait counter and the error decode.

## Test plan
- **Word write/read, W = 0.** Write 0xDEADBEEF at 0x10, then read 0x10 → HRDATA = 0xDEADBEEF, HREADYOUT high every cycle, HRESP = 0.
- **Byte write.** Write byte 0xAA at 0x13 over 0x11223344 at 0x10, then read 0x10 → 0xAA223344.
- **Wait states.** With W = 3, a read shows HREADYOUT low for 3 cycles, then high with valid data; back-to-back writes complete every 4 cycles.
- **Errors.**
  - Write at address DEPTH·4 → two-cycle ERROR (HREADYOUT 0/1, HRESP 1/1); a subsequent read of the affected word is unchanged.
  - Halfword at 0x01 → ERROR.
  - HSIZE = 3 with DATA_WIDTH = 32 → ERROR.
- **IDLE/BUSY and HSEL low** → OKAY, zero wait; an address phase with HREADY = 0 is ignored and memory is unchanged.
- **Reset mid-transfer.** Assert HRESET in the 2nd wait cycle of a W = 3 write → next cycle HREADYOUT = 1, HRESP = 0, HRDATA = 0, and the target word keeps its old value.
